pixbuf_readout: RTL and testbench

//  Drains the pixel-buffer decode/store FIFO (22-bit decoded hits, num_elem fill level, err_overwr flag).

---
 rtl/pixbuf_readout.sv | 148 ++++++++++++++
 tb/tb_pixbuf_readout.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixbuf_readout.sv
// Drains the decode_store hit FIFO and frames the hits as header / data / trailer
// packets on a registered 32-bit valid/ready stream.
module pixbuf_readout #(
  parameter int DATA_W    = 22,
  parameter int CNT_W     = 9,
  parameter int THRESH    = 16,
  parameter int MAX_BURST = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  num_elem,
  input  logic [DATA_W-1:0] data_in,
  input  logic              err_overwr,
  output logic              rd_en,
  output logic [31:0]       m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Stream protocol: a word transfers on a rising clk edge where m_valid && m_ready;
  // once m_valid is raised, m_data and m_valid hold until that transfer happens.

  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_BURST);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_TRL  = 3'd5;

  logic [2:0]        r_state;
  logic [7:0]        r_frame_cnt;
  logic              r_err_sticky;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_m_valid;
  logic [31:0]       r_m_data;

  logic              w_hs;
  logic              w_start;
  logic [CNT_W-1:0]  w_n_start;
  logic [8:0]        w_n_start9;
  logic [8:0]        w_n9;
  logic [31:0]       w_hdr_word;
  logic [31:0]       w_data_word;
  logic [31:0]       w_trl_word;

  assign w_hs    = r_m_valid & m_ready;
  assign w_start = (r_state == ST_IDLE) &&
                   ((num_elem >= THRESH_C) ||
                    ((num_elem != '0) && (r_idle_cnt == IDLE_LAST)));
  assign w_n_start  = (num_elem > MAX_C) ? MAX_C : num_elem;
  assign w_n_start9 = 9'(w_n_start);
  assign w_n9       = 9'(r_n);

  // The header is frozen at frame start, so an error arriving that same cycle is reported.
  assign w_hdr_word  = {8'hA5, r_frame_cnt, r_err_sticky | err_overwr, 6'd0, w_n_start9};
  assign w_data_word = {2'b01, {(30 - DATA_W){1'b0}}, data_in};
  assign w_trl_word  = {8'h5A, 15'd0, w_n9};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_frame_cnt  <= '0;
      r_err_sticky <= 1'b0;
      r_idle_cnt   <= '0;
      r_n          <= '0;
      r_remaining  <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
    end else begin
      if (err_overwr)
        r_err_sticky <= 1'b1;
      else if (r_state == ST_HDR && w_hs)
        r_err_sticky <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_idle_cnt  <= '0;
            r_n         <= w_n_start;
            r_remaining <= w_n_start;
            r_m_valid   <= 1'b1;
            r_m_data    <= w_hdr_word;
            r_state     <= ST_HDR;
          end else if (num_elem == '0) begin
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        ST_HDR: begin
          if (w_hs) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_RD;
          end
        end
        ST_RD: begin
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_m_data    <= w_data_word;
          r_m_valid   <= 1'b1;
          r_remaining <= r_remaining - 1'b1;
          r_state     <= ST_DATA;
        end
        ST_DATA: begin
          if (w_hs) begin
            if (r_remaining != '0) begin
              r_m_valid <= 1'b0;
              r_state   <= ST_RD;
            end else begin
              r_m_data <= w_trl_word;
              r_state  <= ST_TRL;
            end
          end
        end
        ST_TRL: begin
          if (w_hs) begin
            r_m_valid   <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads only ever happen from RD, which is entered only while entries are owed.
  assign rd_en     = (r_state == ST_RD);
  assign busy      = (r_state != ST_IDLE);
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pixbuf_readout.sv
// Directed bench for pixbuf_readout: a small decode_store FIFO model feeds the DUT,
// accepted stream words are scoreboarded against hand-built packets.
module tb_pixbuf_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  num_elem;
  logic [21:0] data_in = '0;
  logic        err_overwr = 1'b0;
  logic        rd_en;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [21:0] fifo_mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          rd_cnt = 0;
  logic        bp_en  = 1'b0;

  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  pixbuf_readout dut (
    .clk        (clk),
    .rst        (rst),
    .num_elem   (num_elem),
    .data_in    (data_in),
    .err_overwr (err_overwr),
    .rd_en      (rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset-free infrastructure
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  // decode_store model: data_out is valid the cycle after an rd_en pulse
  assign num_elem = 9'(wr_ptr - rd_ptr);
  always @(posedge clk) begin
    if (rd_en) begin
      data_in <= fifo_mem[rd_ptr % 512];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = bp_en ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // monitor: collect accepted words, count reads, check stalled words hold
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (rd_en) rd_cnt++;
      if (stall_prev) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready) got_q.push_back(m_data);
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
    end
  end

  // driver tasks
  task automatic push_n(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      fifo_mem[wr_ptr % 512] = 22'(base + i);
      wr_ptr++;
    end
  endtask

  task automatic exp_frame(input logic [7:0] fc, input logic err, input int base, input int n);
    logic [8:0] n9;
    n9 = 9'(n);
    exp_q.push_back({8'hA5, fc, err, 6'd0, n9});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b01, 8'h00, 22'(base + i)});
    exp_q.push_back({8'h5A, 15'd0, n9});
  endtask

  task automatic wait_done(input string tag, input int nwords, input int budget);
    int c;
    c = 0;
    while (!(busy == 1'b0 && got_q.size() >= nwords) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(nwords));
  endtask

  task automatic compare_words(input string tag);
    int idx;
    logic [31:0] g;
    idx = 0;
    while (exp_q.size() > 0) begin
      g = (got_q.size() > 0) ? got_q.pop_front() : 32'hxxxx_xxxx;
      check($sformatf("%s_w%0d", tag, idx), g, exp_q.pop_front());
      idx++;
    end
    got_q.delete();
  endtask

  task automatic wait_data_word(input string tag);
    int c;
    c = 0;
    while (!(m_valid && m_data[31:30] == 2'b01) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, {31'd0, m_valid}, 32'd1);
  endtask

  initial begin
    int c;
    int rd_base;

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_rd_en", {31'd0, rd_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: basic 16-entry frame, header one cycle after start
    rd_base = rd_cnt;
    push_n(32'h1, 16);
    @(posedge clk); #1;
    check("t1_hdr_valid", {31'd0, m_valid}, 32'd1);
    check("t1_hdr_word", m_data, 32'hA500_0010);
    exp_frame(8'd0, 1'b0, 32'h1, 16);
    wait_done("t1", 18, 300);
    check("t1_rd_count", 32'(rd_cnt - rd_base), 32'd16);
    compare_words("t1");

    // 2: three entries wait out the idle timeout
    rd_base = rd_cnt;
    push_n(32'h11, 3);
    c = 0;
    @(posedge clk); #1;
    while (!m_valid && c < 1100) begin
      @(posedge clk); #1;
      c++;
    end
    check("t2_timeout_cycles", 32'(c), 32'd1023);
    check("t2_hdr_word", m_data, 32'hA501_0003);
    exp_frame(8'd1, 1'b0, 32'h11, 3);
    wait_done("t2", 5, 300);
    check("t2_rd_count", 32'(rd_cnt - rd_base), 32'd3);
    compare_words("t2");

    // 3: random back-pressure, same packet shape
    rd_base = rd_cnt;
    bp_en = 1'b1;
    push_n(32'h21, 16);
    exp_frame(8'd2, 1'b0, 32'h21, 16);
    wait_done("t3", 18, 3000);
    bp_en = 1'b0;
    check("t3_rd_count", 32'(rd_cnt - rd_base), 32'd16);
    compare_words("t3");

    // 4: 100 entries split at the burst cap; remainder still above threshold
    rd_base = rd_cnt;
    push_n(32'h100, 100);
    exp_frame(8'd3, 1'b0, 32'h100, 64);
    exp_frame(8'd4, 1'b0, 32'h140, 36);
    wait_done("t4", 104, 1500);
    check("t4_rd_count", 32'(rd_cnt - rd_base), 32'd100);
    compare_words("t4");

    // 5: overwrite error during frame data shows in the next header only
    push_n(32'h200, 16);
    wait_data_word("t5_wait_data");
    err_overwr = 1'b1;
    @(posedge clk); #1;
    err_overwr = 1'b0;
    exp_frame(8'd5, 1'b0, 32'h200, 16);
    wait_done("t5a", 18, 300);
    compare_words("t5a");
    push_n(32'h210, 16);
    @(posedge clk); #1;
    check("t5_err_hdr", m_data, 32'hA506_8010);
    exp_frame(8'd6, 1'b1, 32'h210, 16);
    wait_done("t5b", 18, 300);
    compare_words("t5b");
    push_n(32'h220, 16);
    exp_frame(8'd7, 1'b0, 32'h220, 16);
    wait_done("t5c", 18, 300);
    compare_words("t5c");

    // 6: reset during DATA aborts; the leftover 15 plus one new entry form a clean frame
    push_n(32'h300, 16);
    wait_data_word("t6_wait_data");
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_rd_en", {31'd0, rd_en}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_m_data", m_data, 32'd0);
    rst = 1'b0;
    got_q.delete();
    rd_base = rd_cnt;
    push_n(32'h310, 1);
    exp_frame(8'd0, 1'b0, 32'h301, 16);
    wait_done("t6", 18, 300);
    check("t6_rd_count", 32'(rd_cnt - rd_base), 32'd16);
    compare_words("t6");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
